// File: rtl/attn_seq_pkg.sv
// Shared types and inst-word bit positions for the attention instruction sequencer.
// The inst layout is fixed by the fullchip inst port, so the address fields are always 4 bits wide.
package attn_seq_pkg;

    localparam int INST_W = 17;
    localparam int ADDR_W = 4;

    localparam int INST_OFIFO_RD   = 16;
    localparam int INST_QK_ADD_MSB = 15;
    localparam int INST_QK_ADD_LSB = 12;
    localparam int INST_P_ADD_MSB  = 11;
    localparam int INST_P_ADD_LSB  = 8;
    localparam int INST_EXECUTE    = 7;
    localparam int INST_LOAD       = 6;
    localparam int INST_QMEM_RD    = 5;
    localparam int INST_QMEM_WR    = 4;
    localparam int INST_KMEM_RD    = 3;
    localparam int INST_KMEM_WR    = 2;
    localparam int INST_PMEM_RD    = 1;
    localparam int INST_PMEM_WR    = 0;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LTAIL,
        GAP1,
        EXEC,
        GAP2,
        MOVE,
        PRE,
        ACC,
        NORM,
        DONE
    } state_t;

    // Everything the sequencer drives, registered as one word
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic              acc;
        logic              div;
        logic              wr_norm;
        logic              fifo_ext_rd;
        logic              busy;
        logic              done;
        logic              wr_err;
    } ctrl_t;

endpackage

// File: rtl/attn_seq_ctrl_if.sv
// Host-side request signals and fullchip-side control outputs of the sequencer.
// master = the sequencer, slave = the host/fullchip side.
interface attn_seq_ctrl_if;
    import attn_seq_pkg::*;

    logic              start;
    logic              abort;
    logic              q_wr_valid;
    logic              k_wr_valid;
    logic [INST_W-1:0] inst;
    logic              acc;
    logic              div;
    logic              wr_norm;
    logic              fifo_ext_rd;
    logic              busy;
    logic              done;
    logic              wr_err;

    modport master (
        input  start, abort, q_wr_valid, k_wr_valid,
        output inst, acc, div, wr_norm, fifo_ext_rd, busy, done, wr_err
    );

    modport slave (
        output start, abort, q_wr_valid, k_wr_valid,
        input  inst, acc, div, wr_norm, fifo_ext_rd, busy, done, wr_err
    );

endinterface

// File: rtl/attn_wr_ptr.sv
// Wrapping host-write address pointer: counts 0..DEPTH-1 on inc_i, clr_i returns it to 0.
// DEPTH must not exceed 2**AW.
module attn_wr_ptr
    import attn_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/attn_seq_ctrl.sv
// On-chip instruction sequencer for the two-core attention fullchip: K load, Q execute,
// ofifo drain to pmem, then the normalize accumulate/divide/write-back pass.
module attn_seq_ctrl
    import attn_seq_pkg::*;
#(
    parameter int COL         = 8,
    parameter int TOTAL_CYCLE = 8,
    parameter int GAP         = 10,   // must be at least 1
    parameter int AW          = 4     // must not exceed the 4-bit inst address fields
) (
    input  logic             clk,
    input  logic             reset,
    attn_seq_ctrl_if.master  bus
);

    localparam int CNT_MAX_A = (COL > GAP) ? COL : GAP;
    localparam int CNT_MAX   = (CNT_MAX_A > 2 * TOTAL_CYCLE) ? CNT_MAX_A : 2 * TOTAL_CYCLE;
    localparam int CW_RAW    = $clog2(CNT_MAX + 1);
    // At least AW+1 bits so the NORM row index cnt[AW:1] is always in range
    localparam int CW        = (CW_RAW > AW + 1) ? CW_RAW : AW + 1;

    localparam logic [CW-1:0] LOAD_LAST = CW'(COL);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
    localparam logic [CW-1:0] TC_LAST   = CW'(TOTAL_CYCLE - 1);
    localparam logic [CW-1:0] NORM_LAST = CW'(2 * TOTAL_CYCLE - 1);

    state_t        state_q, state_d;
    state_t        state_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    ctrl_t         ctl_q, ctl_d;

    logic          phase_last;
    logic          wr_any;
    logic          q_inc, k_inc, ptr_clr;
    logic [AW-1:0] q_ptr, k_ptr;
    logic [AW-1:0] c_lo;
    logic [AW-1:0] row;

    attn_wr_ptr #(.DEPTH(TOTAL_CYCLE), .AW(AW)) u_q_ptr (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (ptr_clr),
        .inc_i (q_inc),
        .ptr_o (q_ptr)
    );

    attn_wr_ptr #(.DEPTH(COL), .AW(AW)) u_k_ptr (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (ptr_clr),
        .inc_i (k_inc),
        .ptr_o (k_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
        end
    end

    // Outputs are decoded from the next state/counter so they appear from the entering edge
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        ctl_d      = '0;
        q_inc      = 1'b0;
        k_inc      = 1'b0;
        ptr_clr    = 1'b0;
        phase_last = 1'b0;
        state_nxt  = IDLE;
        wr_any     = bus.q_wr_valid | bus.k_wr_valid;

        if (state_q == IDLE) begin
            cnt_d = '0;
            if (bus.start) begin
                state_d      = LOAD;
                ptr_clr      = 1'b1;
                ctl_d.wr_err = wr_any;
            end else if (bus.q_wr_valid && bus.k_wr_valid) begin
                ctl_d.wr_err = 1'b1;
            end else if (bus.q_wr_valid) begin
                q_inc                                         = 1'b1;
                ctl_d.inst[INST_QMEM_WR]                      = 1'b1;
                ctl_d.inst[INST_QK_ADD_MSB:INST_QK_ADD_LSB]   = ADDR_W'(q_ptr);
            end else if (bus.k_wr_valid) begin
                k_inc                                         = 1'b1;
                ctl_d.inst[INST_KMEM_WR]                      = 1'b1;
                ctl_d.inst[INST_QK_ADD_MSB:INST_QK_ADD_LSB]   = ADDR_W'(k_ptr);
            end
        end else begin
            ctl_d.wr_err = wr_any;
            if (bus.abort) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    LOAD:    begin phase_last = (cnt_q == LOAD_LAST); state_nxt = LTAIL; end
                    LTAIL:   begin phase_last = (cnt_q == CW'(1));    state_nxt = GAP1;  end
                    GAP1:    begin phase_last = (cnt_q == GAP_LAST);  state_nxt = EXEC;  end
                    EXEC:    begin phase_last = (cnt_q == TC_LAST);   state_nxt = GAP2;  end
                    GAP2:    begin phase_last = (cnt_q == GAP_LAST);  state_nxt = MOVE;  end
                    MOVE:    begin phase_last = (cnt_q == TC_LAST);   state_nxt = PRE;   end
                    PRE:     begin phase_last = 1'b1;                 state_nxt = ACC;   end
                    ACC:     begin phase_last = (cnt_q == TC_LAST);   state_nxt = NORM;  end
                    NORM:    begin phase_last = (cnt_q == NORM_LAST); state_nxt = DONE;  end
                    default: begin phase_last = 1'b1;                 state_nxt = IDLE;  end
                endcase
                if (phase_last) begin
                    state_d = state_nxt;
                    cnt_d   = '0;
                end
            end
        end

        c_lo = cnt_d[AW-1:0];
        row  = cnt_d[AW:1];

        case (state_d)
            LOAD: begin
                ctl_d.busy             = 1'b1;
                ctl_d.inst[INST_LOAD]  = 1'b1;
                if (cnt_d != '0) begin
                    ctl_d.inst[INST_KMEM_RD]                    = 1'b1;
                    ctl_d.inst[INST_QK_ADD_MSB:INST_QK_ADD_LSB] = ADDR_W'(c_lo - AW'(1));
                end
            end
            LTAIL: begin
                ctl_d.busy            = 1'b1;
                ctl_d.inst[INST_LOAD] = (cnt_d == '0);
            end
            GAP1, GAP2: begin
                ctl_d.busy = 1'b1;
            end
            EXEC: begin
                ctl_d.busy                                  = 1'b1;
                ctl_d.inst[INST_EXECUTE]                    = 1'b1;
                ctl_d.inst[INST_QMEM_RD]                    = 1'b1;
                ctl_d.inst[INST_QK_ADD_MSB:INST_QK_ADD_LSB] = ADDR_W'(c_lo);
            end
            MOVE: begin
                ctl_d.busy                                = 1'b1;
                ctl_d.inst[INST_OFIFO_RD]                 = 1'b1;
                ctl_d.inst[INST_PMEM_WR]                  = 1'b1;
                ctl_d.inst[INST_P_ADD_MSB:INST_P_ADD_LSB] = ADDR_W'(c_lo);
            end
            PRE: begin
                ctl_d.busy               = 1'b1;
                ctl_d.inst[INST_PMEM_RD] = 1'b1;
            end
            ACC: begin
                ctl_d.busy                                = 1'b1;
                ctl_d.acc                                 = 1'b1;
                ctl_d.inst[INST_PMEM_RD]                  = 1'b1;
                ctl_d.inst[INST_P_ADD_MSB:INST_P_ADD_LSB] = ADDR_W'(c_lo);
            end
            NORM: begin
                // Even counts divide a row, odd counts write the normalized row back
                ctl_d.busy                                = 1'b1;
                ctl_d.inst[INST_P_ADD_MSB:INST_P_ADD_LSB] = ADDR_W'(row);
                if (!cnt_d[0]) begin
                    ctl_d.inst[INST_PMEM_RD] = 1'b1;
                    ctl_d.div                = 1'b1;
                    ctl_d.fifo_ext_rd        = 1'b1;
                end else begin
                    ctl_d.inst[INST_PMEM_WR] = 1'b1;
                    ctl_d.wr_norm            = 1'b1;
                end
            end
            DONE: begin
                ctl_d.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.inst        = ctl_q.inst;
    assign bus.acc         = ctl_q.acc;
    assign bus.div         = ctl_q.div;
    assign bus.wr_norm     = ctl_q.wr_norm;
    assign bus.fifo_ext_rd = ctl_q.fifo_ext_rd;
    assign bus.busy        = ctl_q.busy;
    assign bus.done        = ctl_q.done;
    assign bus.wr_err      = ctl_q.wr_err;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Directed bench for attn_seq_ctrl: table of IDLE/handshake vectors, full-run timeline
// model at the defaults, abort/reset corner sequences and a second instance with swept parameters.
module tb_attn_seq_ctrl;

    localparam int COL = 8;
    localparam int TC  = 8;
    localparam int GAP = 10;

    localparam int S_COL = 4;
    localparam int S_TC  = 16;
    localparam int S_GAP = 2;

    localparam logic [16:0] OF  = 17'h10000;
    localparam logic [16:0] EXE = 17'h00080;
    localparam logic [16:0] LD  = 17'h00040;
    localparam logic [16:0] QRD = 17'h00020;
    localparam logic [16:0] QWR = 17'h00010;
    localparam logic [16:0] KRD = 17'h00008;
    localparam logic [16:0] KWR = 17'h00004;
    localparam logic [16:0] PRD = 17'h00002;
    localparam logic [16:0] PWR = 17'h00001;

    localparam logic [6:0] F_ACC  = 7'h40;
    localparam logic [6:0] F_DIV  = 7'h20;
    localparam logic [6:0] F_WN   = 7'h10;
    localparam logic [6:0] F_FIFO = 7'h08;
    localparam logic [6:0] F_BUSY = 7'h04;
    localparam logic [6:0] F_DONE = 7'h02;
    localparam logic [6:0] F_ERR  = 7'h01;

    typedef struct packed {
        logic        q;
        logic        k;
        logic        st;
        logic        ab;
        logic [23:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    vec_t vecs[$];

    attn_seq_ctrl_if bus1();
    attn_seq_ctrl_if bus2();

    attn_seq_ctrl #(.COL(COL), .TOTAL_CYCLE(TC), .GAP(GAP), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    attn_seq_ctrl #(.COL(S_COL), .TOTAL_CYCLE(S_TC), .GAP(S_GAP), .AW(4)) dut_sweep (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] qka(input int a);
        return 17'((a & 15) << 12);
    endfunction

    function automatic logic [16:0] pa(input int a);
        return 17'((a & 15) << 8);
    endfunction

    function automatic logic [23:0] pk(input logic [16:0] i, input logic [6:0] f);
        return {i, f};
    endfunction

    function automatic logic [23:0] act1();
        return {bus1.inst, bus1.acc, bus1.div, bus1.wr_norm, bus1.fifo_ext_rd,
                bus1.busy, bus1.done, bus1.wr_err};
    endfunction

    // Expected outputs n cycles after the start edge, default parameters
    function automatic logic [23:0] model(input int n);
        int ex, mv, pr, ac, nm, dn, k;
        logic [16:0] i;
        logic [6:0]  f;
        i  = '0;
        f  = '0;
        ex = COL + 3 + GAP;
        mv = ex + TC + GAP;
        pr = mv + TC;
        ac = pr + 1;
        nm = ac + TC;
        dn = nm + 2 * TC;
        if (n < 0) begin
        end else if (n <= COL) begin
            i = LD;
            if (n >= 1) i = i | KRD | qka(n - 1);
            f = F_BUSY;
        end else if (n == COL + 1) begin
            i = LD;
            f = F_BUSY;
        end else if (n < ex) begin
            f = F_BUSY;
        end else if (n < ex + TC) begin
            i = EXE | QRD | qka(n - ex);
            f = F_BUSY;
        end else if (n < mv) begin
            f = F_BUSY;
        end else if (n < pr) begin
            i = OF | PWR | pa(n - mv);
            f = F_BUSY;
        end else if (n == pr) begin
            i = PRD;
            f = F_BUSY;
        end else if (n < nm) begin
            i = PRD | pa(n - ac);
            f = F_ACC | F_BUSY;
        end else if (n < dn) begin
            k = n - nm;
            if ((k % 2) == 0) begin
                i = PRD | pa(k / 2);
                f = F_DIV | F_FIFO | F_BUSY;
            end else begin
                i = PWR | pa(k / 2);
                f = F_WN | F_BUSY;
            end
        end else if (n == dn) begin
            f = F_DONE;
        end
        return pk(i, f);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic q, input logic k, input logic st, input logic ab,
                        input logic [23:0] exp);
        vec_t v;
        v.q   = q;
        v.k   = k;
        v.st  = st;
        v.ab  = ab;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic run_full(input string tag);
        int dn;
        dn = COL + 3 + 2 * GAP + 5 * TC + 1;
        bus1.start = 1'b1;
        for (int n = 0; n <= dn + 1; n++) begin
            step();
            bus1.start = 1'b0;
            chk($sformatf("%s_c%0d", tag, n), 32'(act1()), 32'(model(n)));
        end
    endtask

    initial begin
        int ac, ex, done_cnt, busy_cnt, exec_idx, done_at;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.q_wr_valid = 1'b0; bus1.k_wr_valid = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.q_wr_valid = 1'b0; bus2.k_wr_valid = 1'b0;

        // IDLE writes, conflicts, start/abort handshakes
        for (int i = 0; i < 8; i++) addv(1, 0, 0, 0, pk(QWR | qka(i), 7'h0));
        for (int i = 0; i < 9; i++) addv(0, 1, 0, 0, pk(KWR | qka(i % 8), 7'h0));
        addv(1, 1, 0, 0, pk(17'h0, F_ERR));
        addv(1, 0, 0, 0, pk(QWR | qka(0), 7'h0));
        addv(0, 1, 0, 0, pk(KWR | qka(1), 7'h0));
        addv(1, 0, 0, 1, pk(QWR | qka(1), 7'h0));
        addv(0, 0, 0, 0, pk(17'h0, 7'h0));
        addv(1, 0, 1, 0, pk(LD, F_BUSY | F_ERR));
        addv(0, 0, 0, 0, pk(LD | KRD | qka(0), F_BUSY));
        addv(0, 1, 1, 0, pk(LD | KRD | qka(1), F_BUSY | F_ERR));
        addv(0, 0, 0, 1, pk(17'h0, 7'h0));
        addv(1, 0, 0, 0, pk(QWR | qka(0), 7'h0));
        addv(0, 1, 0, 0, pk(KWR | qka(0), 7'h0));

        step();
        step();
        chk("reset_state", 32'(act1()), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_reset_idle", 32'(act1()), 32'h0);

        foreach (vecs[i]) begin
            bus1.q_wr_valid = vecs[i].q;
            bus1.k_wr_valid = vecs[i].k;
            bus1.start      = vecs[i].st;
            bus1.abort      = vecs[i].ab;
            step();
            chk($sformatf("vec%0d", i), 32'(act1()), 32'(vecs[i].exp));
        end
        bus1.q_wr_valid = 1'b0; bus1.k_wr_valid = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;

        run_full("run");

        // Abort while ACC count 3 is showing
        ac = COL + 3 + 2 * GAP + 2 * TC + 1;
        done_cnt = 0;
        bus1.start = 1'b1;
        for (int n = 0; n <= ac + 3; n++) begin
            step();
            bus1.start = 1'b0;
            if (bus1.done) done_cnt++;
        end
        chk("abort_pre_state", 32'(act1()), 32'(model(ac + 3)));
        bus1.abort = 1'b1;
        step();
        bus1.abort = 1'b0;
        chk("abort_outputs", 32'(act1()), 32'h0);
        for (int n = 0; n < 80; n++) begin
            step();
            if (bus1.done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'h0);
        run_full("rerun");

        // Asynchronous reset at EXEC count 5
        ex = COL + 3 + GAP;
        bus1.start = 1'b1;
        for (int n = 0; n <= ex + 5; n++) begin
            step();
            bus1.start = 1'b0;
        end
        chk("exec5_state", 32'(act1()), 32'(model(ex + 5)));
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_out", 32'(act1()), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_full("after_rst");

        // Swept instance
        busy_cnt = 0;
        exec_idx = 0;
        done_at  = -1;
        bus2.start = 1'b1;
        for (int n = 0; n < 200 && done_at < 0; n++) begin
            step();
            bus2.start = 1'b0;
            if (bus2.busy) busy_cnt++;
            if (bus2.inst[7]) begin
                chk($sformatf("sweep_exec_addr%0d", exec_idx), 32'(bus2.inst[15:12]), 32'(exec_idx));
                exec_idx++;
            end
            if (bus2.done) done_at = n;
        end
        chk("sweep_exec_count", 32'(exec_idx), 32'(S_TC));
        chk("sweep_busy_len", 32'(busy_cnt), 32'(S_COL + 3 + 2 * S_GAP + 5 * S_TC + 1));
        chk("sweep_done_at", 32'(done_at), 32'(S_COL + 3 + 2 * S_GAP + 5 * S_TC + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
